// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debounce_pkg                                                 |
// | Description : Shared per-button debounce state and tick period default.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package debounce_pkg;

    localparam int TICK_CYCLES_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD1    = 2'd1,
        HOLD2    = 2'd2,
        REL_WAIT = 2'd3
    } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tick_gen                                                     |
// | Description : Free-running 0..TICK_CYCLES-1 counter, one-cycle tick pulse. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : (cnt_q + CW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_scan_controller                                       |
// | Description : Debounces N_BTN buttons and emits press/release events via  |
// |               a round-robin arbiter into a one-entry valid/ready stage.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module button_scan_controller
    import debounce_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         sw,
    output logic [N_BTN-1:0]         db,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_press,
    output logic [N_BTN-1:0]         ovf
);

    localparam int IDW = $clog2(N_BTN);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sws_q;
    logic             w_tick;

    logic [N_BTN-1:0] w_set_press;
    logic [N_BTN-1:0] w_set_rel;
    logic [N_BTN-1:0] w_clr_press;
    logic [N_BTN-1:0] w_clr_rel;

    logic [N_BTN-1:0] press_pend_q, press_pend_d;
    logic [N_BTN-1:0] rel_pend_q, rel_pend_d;
    logic [N_BTN-1:0] ovf_q, ovf_d;

    logic [IDW-1:0]   rr_q, rr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDW-1:0]   evt_id_q, evt_id_d;
    logic             evt_press_q, evt_press_d;

    logic             w_grant_valid;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_grant_press;
    logic             w_load;

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sws_q   <= '0;
        end else begin
            sync1_q <= sw;
            sws_q   <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_state_t st_q, st_d;
        logic       set_p, set_r;

        always_comb begin
            st_d  = st_q;
            set_p = 1'b0;
            set_r = 1'b0;
            unique case (st_q)
                IDLE: begin
                    if (sws_q[gi]) begin
                        st_d  = HOLD1;
                        set_p = 1'b1;
                    end
                end
                HOLD1:    if (w_tick) st_d = HOLD2;
                HOLD2:    if (w_tick) st_d = REL_WAIT;
                REL_WAIT: begin
                    if (!sws_q[gi]) begin
                        st_d  = IDLE;
                        set_r = 1'b1;
                    end
                end
                default:  st_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_q <= IDLE;
            end else begin
                st_q <= st_d;
            end
        end

        assign db[gi]          = (st_q != IDLE);
        assign w_set_press[gi] = set_p;
        assign w_set_rel[gi]   = set_r;
    end

    // Scan downward so the candidate nearest after rr_q is the last writer.
    always_comb begin
        int cand;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_grant_press = 1'b0;
        cand          = 0;
        for (int k = N_BTN; k >= 1; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= N_BTN) begin
                cand = cand - N_BTN;
            end
            if (press_pend_q[cand] || rel_pend_q[cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = IDW'(cand);
                w_grant_press = press_pend_q[cand];
            end
        end
    end

    assign w_load = !evt_valid_q || evt_ready;

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_press_d = evt_press_q;
        rr_d        = rr_q;
        w_clr_press = '0;
        w_clr_rel   = '0;
        if (w_load) begin
            evt_valid_d = w_grant_valid;
            if (w_grant_valid) begin
                evt_id_d    = w_grant_idx;
                evt_press_d = w_grant_press;
                rr_d        = w_grant_idx;
                if (w_grant_press) begin
                    w_clr_press[w_grant_idx] = 1'b1;
                end else begin
                    w_clr_rel[w_grant_idx] = 1'b1;
                end
            end
        end
    end

    // A grant clears before a same-cycle set, so a fresh event survives the grant.
    always_comb begin
        press_pend_d = (press_pend_q & ~w_clr_press) | w_set_press;
        rel_pend_d   = (rel_pend_q & ~w_clr_rel) | w_set_rel;
        ovf_d        = ovf_q
                     | (press_pend_q & ~w_clr_press & w_set_press)
                     | (rel_pend_q & ~w_clr_rel & w_set_rel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            ovf_q        <= '0;
            rr_q         <= IDW'(N_BTN - 1);
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_press_q  <= 1'b0;
        end else begin
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            ovf_q        <= ovf_d;
            rr_q         <= rr_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_press_q  <= evt_press_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_press = evt_press_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_button_scan_controller                                    |
// | Description : Scoreboard bench with an event-level reference model.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_button_scan_controller;

    localparam int N = 4;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw;
    logic [N-1:0] db;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic         evt_press;
    logic [N-1:0] ovf;
    logic         done;

    int errors = 0;
    int checks = 0;

    button_scan_controller #(
        .N_BTN       (N),
        .TICK_CYCLES (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .db        (db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: button "pressed" flag plus count of ticks seen while pressed.
    int           tcnt;
    logic [N-1:0] s1, s2, pressed, pend_p, pend_r, m_ovf;
    int           ticks [N];
    logic         m_busy;
    int           last;
    int           exp_q [$];

    always @(posedge clk or negedge reset) begin
        bit           tk;
        logic [N-1:0] sws;
        bit           found;
        int           idx;
        bit           sp, sr;
        if (!reset) begin
            tcnt = 0; s1 = '0; s2 = '0; pressed = '0; pend_p = '0; pend_r = '0;
            m_ovf = '0; m_busy = 1'b0; last = N - 1;
            for (int i = 0; i < N; i++) ticks[i] = 0;
            exp_q.delete();
        end else begin
            tk   = (tcnt == T - 1);
            tcnt = (tcnt + 1) % T;
            sws  = s2;
            s2   = s1;
            s1   = sw;
            if (!m_busy || evt_ready) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (!found && (pend_p[idx] || pend_r[idx])) begin
                        found = 1;
                        last  = idx;
                        if (pend_p[idx]) begin
                            pend_p[idx] = 1'b0;
                            exp_q.push_back(idx * 2 + 1);
                        end else begin
                            pend_r[idx] = 1'b0;
                            exp_q.push_back(idx * 2);
                        end
                    end
                end
                m_busy = found;
            end
            for (int i = 0; i < N; i++) begin
                sp = 0; sr = 0;
                if (!pressed[i]) begin
                    if (sws[i]) begin pressed[i] = 1'b1; ticks[i] = 0; sp = 1; end
                end else if (ticks[i] < 2) begin
                    if (tk) ticks[i]++;
                end else if (!sws[i]) begin
                    pressed[i] = 1'b0; sr = 1;
                end
                if (sp) begin if (pend_p[i]) m_ovf[i] = 1'b1; else pend_p[i] = 1'b1; end
                if (sr) begin if (pend_r[i]) m_ovf[i] = 1'b1; else pend_r[i] = 1'b1; end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic       prev_hold;
    logic [1:0] prev_id;
    logic       prev_press;
    int         e;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            #1;
            check("reset_db", int'(db), 0);
            check("reset_valid", int'(evt_valid), 0);
            check("reset_id", int'(evt_id), 0);
            check("reset_press", int'(evt_press), 0);
            check("reset_ovf", int'(ovf), 0);
            prev_hold = 1'b0;
        end else begin
            check("db", int'(db), int'(pressed));
            check("evt_valid", int'(evt_valid), int'(m_busy));
            check("ovf", int'(ovf), int'(m_ovf));
            if (prev_hold) begin
                check("hold_id", int'(evt_id), int'(prev_id));
                check("hold_press", int'(evt_press), int'(prev_press));
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'(evt_id) * 2 + int'(evt_press), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_id", int'(evt_id), e / 2);
                    check("evt_press", int'(evt_press), e % 2);
                end
            end
            prev_hold  = evt_valid && !evt_ready;
            prev_id    = evt_id;
            prev_press = evt_press;
            if (done) begin
                check("drained", exp_q.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1; sw = '0; evt_ready = 1'b0; done = 1'b0;
        #2 reset = 1'b0;
        cyc(3);
        reset = 1'b1;

        // single press and release on button 2
        evt_ready = 1'b1; sw[2] = 1'b1; cyc(40);
        sw[2] = 1'b0; cyc(30);

        // bouncing button 1
        sw[1] = 1'b1;
        for (int j = 0; j < 6; j++) begin cyc(2); sw[1] = ~sw[1]; end
        cyc(20); sw[1] = 1'b0; cyc(30);

        // simultaneous presses on 0, 1, 3
        sw = 4'b1011; cyc(30);
        sw = '0; cyc(30);

        // backpressure on button 0
        evt_ready = 1'b0; sw[0] = 1'b1; cyc(25);
        sw[0] = 1'b0; cyc(10);
        evt_ready = 1'b1; cyc(10);

        // overflow on button 3 while the slot is held by button 0
        evt_ready = 1'b0; sw[0] = 1'b1; cyc(5);
        for (int j = 0; j < 2; j++) begin
            sw[3] = 1'b1; cyc(25);
            sw[3] = 1'b0; cyc(6);
        end
        evt_ready = 1'b1; cyc(10);
        sw[0] = 1'b0; cyc(30);

        // reset while an event is presented and db = 0101
        evt_ready = 1'b0; sw = 4'b0101; cyc(8);
        reset = 1'b0;
        sw = '0; cyc(2);
        reset = 1'b1; cyc(30);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 24) == 0) sw[b] = ~sw[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        sw = '0; evt_ready = 1'b1; cyc(60);
        done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/button_scan_controller.md
BUTTON_SCAN_CONTROLLER -- requirements
Module: button_scan_controller

Interface
REQ-001 Parameter N_BTN, default 4, is the number of button inputs (2..16).
REQ-002 Parameter TICK_CYCLES, default 1_000_000, is clk cycles per debounce tick (10 ms at 100 MHz); minimum 4.
REQ-003 clk  input  1  single clock; all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sw  input  N_BTN  raw, asynchronous button levels; 1 = pressed.
REQ-006 db  output  N_BTN  debounced levels, one per button.
REQ-007 evt_valid  output  1  an event is presented.
REQ-008 evt_ready  input  1  consumer accepts the event when high together with evt_valid.
REQ-009 evt_id  output  clog2(N_BTN)  index of the button that produced the event.
REQ-010 evt_press  output  1  1 = press event, 0 = release event.
REQ-011 ovf  output  N_BTN  sticky flag: an event was lost on that button.

Function
REQ-012 Each sw bit SHALL pass through a 2-flop synchronizer; only the synchronized value (sws) feeds the logic.
REQ-013 One shared tick counter SHALL count 0..TICK_CYCLES-1 free-running, pulsing tick for one cycle at TICK_CYCLES-1, then wrapping to 0.
REQ-014 Each button SHALL hold a 2-bit state: IDLE, HOLD1, HOLD2, REL_WAIT.
REQ-015 Transitions: IDLE and sws -> HOLD1; HOLD1 and tick -> HOLD2; HOLD2 and tick -> REL_WAIT; REL_WAIT and !sws -> IDLE; otherwise hold.
REQ-016 db[i] SHALL be 0 in IDLE and 1 in every other state, decoded from registered state (glitch-free).
REQ-017 Net effect: db rises 3 clk edges after sw rises, ignoring bounce; once high, db stays high for at least TICK_CYCLES+1 cycles and at most 2*TICK_CYCLES cycles, plus the time sws stays high.
REQ-018 The IDLE->HOLD1 transition SHALL set press_pend[i]; the REL_WAIT->IDLE transition SHALL set rel_pend[i].
REQ-019 If a pending bit is already set when its set condition recurs, the bit SHALL stay set and ovf[i] SHALL be set.
REQ-020 The output stage SHALL be a one-entry register. It loads when empty, or when evt_valid and evt_ready are both high in the same cycle (back-to-back throughput: one event per cycle).
REQ-021 Selection SHALL be round-robin over buttons, starting at the index after the last granted button; the first pending button found wins.
REQ-022 Within a button, press_pend SHALL be granted before rel_pend.
REQ-023 Granting SHALL clear the selected pending bit in the same edge that loads the output register.
REQ-024 A pending bit set and granted in the same cycle: the set wins only if it is a new event on an already-cleared bit; the granted bit clears, and the new event is not lost.
REQ-025 While evt_valid is high and evt_ready is low, evt_id and evt_press SHALL remain stable.
REQ-026 The minimum latency from pending-set to evt_valid is 1 cycle when the output stage is empty.

Reset
REQ-027 Reset assertion SHALL asynchronously force the following: synchronizers 0, tick counter 0, all states IDLE, pending bits 0, rr pointer to N_BTN-1, ovf 0, evt_valid 0, evt_id 0, evt_press 0, db 0.
REQ-028 Reset mid-operation SHALL discard all pending and presented events with no partial handshake.
REQ-029 Reset deassertion is assumed synchronized externally; the first tick occurs TICK_CYCLES cycles after release.

Structure
REQ-030 A shared package debounce_pkg SHALL hold the btn_state_t enum (IDLE, HOLD1, HOLD2, REL_WAIT) and the TICK_CYCLES default constant.
REQ-031 The tick counter SHALL be a sub-module tick_gen with parameter TICK_CYCLES, ports clk, reset, and output tick.
REQ-032 Per-button FSMs, the pending logic, the arbiter and the output register SHALL live in button_scan_controller.

Verification (N_BTN=4, TICK_CYCLES=8)
REQ-033 Single press: sw[2] goes 0->1 and stays high, evt_ready=1 -> db[2]=1 at the 3rd edge; one event with id=2 and press=1; no further events while held.
REQ-034 Bounce: sw[1] toggles every 2 cycles for 12 cycles after the first rise -> db[1] stays 1 throughout; exactly one press event is produced; the release event follows only after sw settles low.
REQ-035 Arbitration: sw[0], sw[1] and sw[3] rise in the same cycle with evt_ready=1 -> events are produced on consecutive cycles with ids 0, 1, 3.
REQ-036 Backpressure: with evt_ready=0, press then release button 0 -> the first event is held stable; the second is queued; evt_ready=1 -> press then release events for id 0 are produced; ovf=0.
REQ-037 Overflow: with evt_ready=0, button 3 completes two press/release cycles -> ovf[3]=1; exactly one press and one release are delivered when ready.
REQ-038 Reset mid-operation: reset asserted while evt_valid=1 and db=4'b0101 -> all outputs go to 0 immediately; after release, no stale events appear.
